byte_lane_memory: RTL and testbench
===================================

Name: byte_lane_memory

Overview:
- Next-generation data memory for the ARM core's load/store path.
- Byte-addressed and little-endian, with byte, halfword and word accesses, signed or unsigned load extension, and alignment and range fault detection.
- Uses a valid/ready request/response handshake with a configurable access latency.
- Sits between the load/store unit and backing storage; replaces the fixed word-only read/write memory.

Parameters:
- SIZE, 64000, memory depth in bytes.
- ADDR_W, 32, request address width.
- LATENCY, 1, cycles from request accept to resp_valid; legal range 1..8.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved
- req_signed  in  1  loads only: sign-extend sub-word data
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data; low bytes used for sub-word stores
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  load data, zero- or sign-extended; 0 for stores and faults
- resp_fault  out  1  access rejected (misaligned, reserved size, or out of range)

Behaviour:
- Clock is clk; reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, latency counter=0. Memory contents are not cleared.
- FSM states:
  - IDLE: req_ready=1. Accept occurs on req_valid&req_ready at a rising edge. If LATENCY==1, go to RESP; otherwise go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Counter decrements each cycle; at 1, go to RESP.
  - RESP: resp_valid=1, req_ready=0. On resp_ready, go to IDLE. Outputs hold stable while resp_ready=0.
- Latency: resp_valid rises exactly LATENCY cycles after the accept edge. At most one transaction is outstanding, so back-to-back throughput is one per LATENCY+1 cycles minimum.
- Fault check at accept, evaluated in this order; any hit sets resp_fault=1 and resp_rdata=0:
  - req_size==11.
  - Halfword with addr[0]!=0.
  - Word with addr[1:0]!=0.
  - addr + nbytes > SIZE, where nbytes is 1, 2 or 4. Compute at ADDR_W+1 bits so there is no wrap-around.
- A faulting store writes nothing.
- Stores commit to memory on the accept edge. A load accepted later observes them.
  - Byte store: mem[a] = wdata[7:0].
  - Halfword store: mem[a] = wdata[7:0], mem[a+1] = wdata[15:8].
  - Word store: bytes 0..3 little-endian at a..a+3.
- Loads sample memory on the accept edge and hold the result through WAIT and RESP.
  - Byte load: data[7:0]. Bits 31:8 = req_signed ? {24{data[7]}} : 0.
  - Halfword load: data[15:0]. Bits 31:16 = req_signed ? {16{data[15]}} : 0.
  - Word load: req_signed is ignored.
- Stores return resp_valid with rdata=0 and fault=0, or fault=1 if rejected.
- Request inputs are ignored when req_ready=0; no queueing.
- Reset mid-operation: the pending response is discarded and the FSM returns to IDLE. A store already accepted remains committed.
- Simultaneous resp_ready and a new req_valid in RESP: the response completes; the new request is accepted no earlier than the next cycle, in IDLE.

Test Plan:
- Word store then load, LATENCY=1: store 0xDEADBEEF @0x100, then load word @0x100 -> resp_rdata=0xDEADBEEF, fault=0. A byte load @0x103 unsigned -> 0x000000DE.
- Sub-word extension: store byte 0x80 @0x10; byte load signed -> 0xFFFFFF80, unsigned -> 0x00000080. Store half 0x8001 @0x20; half load signed -> 0xFFFF8001.
- Faults: word load @0x102 -> fault=1, rdata=0. Half store @0x21 -> fault=1, and a later word load @0x20 is unchanged. size=11 -> fault=1. Word load @SIZE-2 -> fault=1. Word load @SIZE-4 -> fault=0.
- Latency and backpressure, LATENCY=4: accept at cycle 0 -> resp_valid at cycle 4, req_ready=0 during cycles 1..4. Hold resp_ready=0 for 3 cycles -> rdata/fault stable; req_ready returns only after the handshake.
- Reset mid-WAIT (LATENCY=4): accept store 0x12345678 @0x40, assert reset at cycle 2 -> resp_valid never asserts, req_ready=1 after reset. A following load @0x40 returns 0x12345678.
- Ignored request: drive req_valid with a store to @0x50 while in WAIT -> no write occurs; a load @0x50 returns its prior value.

Source files
------------

// File: rtl/byte_lane_memory.sv
// Byte-addressed little-endian data memory with byte/halfword/word access,
// load extension, fault detection and a single-outstanding valid/ready handshake.
module byte_lane_memory #(
  parameter int unsigned SIZE    = 64000,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault
);

  localparam int unsigned Words = (SIZE + 3) / 4;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned CntW  = 4;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            fault_q, fault_d;

  // Word-organised storage; aligned sub-word accesses map onto byte lanes.
  logic [31:0]     mem [Words];

  logic            accept;
  logic [2:0]      nbytes;
  logic [ADDR_W:0] end_addr;
  logic            fault;
  logic [IdxW-1:0] word_idx;
  logic [1:0]      lane;
  logic [3:0]      be;
  logic [31:0]     wlane;
  logic            store_en;
  logic [31:0]     rword, rshift, load_data;

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

  assign accept   = req_valid & req_ready;
  assign word_idx = req_addr[IdxW+1:2];
  assign lane     = req_addr[1:0];

  always_comb begin
    nbytes = 3'd4;
    unique case (req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // One extra bit so that addresses near the top of the space cannot wrap.
  assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(nbytes);

  always_comb begin
    fault = 1'b0;
    if (req_size == 2'b11) begin
      fault = 1'b1;
    end else if (req_size == 2'b01 && req_addr[0]) begin
      fault = 1'b1;
    end else if (req_size == 2'b10 && req_addr[1:0] != 2'b00) begin
      fault = 1'b1;
    end else if (end_addr > (ADDR_W+1)'(SIZE)) begin
      fault = 1'b1;
    end
  end

  always_comb begin
    be    = 4'b1111;
    wlane = req_wdata;
    unique case (req_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {lane[1], 1'b0};
        wlane = {2{req_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = req_wdata;
      end
    endcase
  end

  assign store_en = accept & req_write & ~fault & ~reset;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (store_en && be[i]) begin
        mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_comb begin
    rword     = mem[word_idx];
    rshift    = rword >> {lane, 3'b000};
    load_data = rshift;
    unique case (req_size)
      2'b00:   load_data = {{24{req_signed & rshift[7]}}, rshift[7:0]};
      2'b01:   load_data = {{16{req_signed & rshift[15]}}, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          fault_d = fault;
          rdata_d = (fault || req_write) ? 32'h0 : load_data;
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_byte_lane_memory.sv
// Bench for byte_lane_memory: two instances (latency 1 and 4) checked every cycle
// against a byte-array transaction model, plus directed literal expectations.
module tb_byte_lane_memory;

  localparam int unsigned SIZE = 64000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [1:0]  req_size [2];
  logic        req_signed [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_fault [2];

  byte_lane_memory #(.SIZE(SIZE), .ADDR_W(32), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0])
  );

  byte_lane_memory #(.SIZE(SIZE), .ADDR_W(32), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1])
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: per-instance byte image with a known flag, plus pending-response timing.
  logic [7:0]  mm [2][SIZE];
  bit          kn [2][SIZE];
  int          pend [2];
  int          left [2];
  logic [31:0] e_rd [2];
  logic [31:0] e_mask [2];
  logic        e_flt [2];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input logic [31:0] mask = 32'hFFFF_FFFF);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act & mask, exp & mask);
    end
  endtask

  task automatic model_accept(input int d);
    int          nb;
    longint      a;
    bit          flt;
    logic [31:0] v, m;
    a   = longint'(req_addr[d]);
    nb  = (req_size[d] == 2'd0) ? 1 : (req_size[d] == 2'd1) ? 2 : 4;
    flt = (req_size[d] == 2'd3) || ((a % nb) != 0) || (a + nb > SIZE);
    v   = 32'h0;
    m   = 32'hFFFF_FFFF;
    if (!flt && req_write[d]) begin
      for (int i = 0; i < nb; i++) begin
        mm[d][a+i] = req_wdata[d][8*i +: 8];
        kn[d][a+i] = 1'b1;
      end
    end else if (!flt) begin
      m = 32'h0;
      for (int i = 0; i < nb; i++) begin
        v[8*i +: 8] = mm[d][a+i];
        if (kn[d][a+i]) m[8*i +: 8] = 8'hFF;
      end
      for (int b = nb * 8; b < 32; b++) begin
        v[b] = req_signed[d] ? v[nb*8-1] : 1'b0;
        m[b] = req_signed[d] ? m[nb*8-1] : 1'b1;
      end
    end
    e_rd[d]   = v;
    e_mask[d] = m;
    e_flt[d]  = flt;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst[d]) begin
          pend[d] = 0;
        end else if (pend[d] != 0) begin
          if (left[d] > 0) left[d]--;
          else if (resp_ready[d]) pend[d] = 0;
        end else if (req_valid[d]) begin
          model_accept(d);
          pend[d] = 1;
          left[d] = lat(d) - 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("L%0d req_ready", lat(d)), 32'(req_ready[d]), 32'(pend[d] == 0));
          chk($sformatf("L%0d resp_valid", lat(d)), 32'(resp_valid[d]),
              32'(pend[d] != 0 && left[d] == 0));
          if (pend[d] != 0 && left[d] == 0) begin
            chk($sformatf("L%0d model rdata", lat(d)), resp_rdata[d], e_rd[d], e_mask[d]);
            chk($sformatf("L%0d model fault", lat(d)), 32'(resp_fault[d]), 32'(e_flt[d]));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_size[d]   = sz;
    req_signed[d] = sg;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
  endtask

  task automatic wait_resp(input int d, output logic [31:0] rd, output logic f);
    int n = 0;
    while (!resp_valid[d] && n < 32) begin
      @(posedge clk); #1;
      n++;
    end
    if (!resp_valid[d]) begin
      checks++;
      errors++;
      $display("FAIL L%0d response timeout: got no resp_valid expected resp_valid", lat(d));
    end
    rd = resp_rdata[d];
    f  = resp_fault[d];
  endtask

  // Assumes the instance is idle; returns with the response consumed.
  task automatic xact(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic f);
    drive(d, wr, sz, sg, a, wd);
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    wait_resp(d, rd, f);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        f;
    int          n;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      resp_ready[d] = 1'b0;
      drive(d, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      req_valid[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0;
      chk("reset req_ready", 32'(req_ready[d]), 32'h1);
      chk("reset resp_valid", 32'(resp_valid[d]), 32'h0);
      chk("reset rdata", resp_rdata[d], 32'h0);
      chk("reset fault", 32'(resp_fault[d]), 32'h0);
    end
    chk_en = 1'b1;

    // Latency 1: data path, extension and faults.
    xact(0, 1, 2'd2, 0, 32'h100, 32'hDEAD_BEEF, rd, f);
    chk("word store rdata", rd, 32'h0);
    chk("word store fault", 32'(f), 32'h0);
    xact(0, 0, 2'd2, 0, 32'h100, 32'h0, rd, f);
    chk("word load", rd, 32'hDEAD_BEEF);
    chk("word load fault", 32'(f), 32'h0);
    xact(0, 0, 2'd0, 0, 32'h103, 32'h0, rd, f);
    chk("byte load 0x103", rd, 32'h0000_00DE);
    xact(0, 1, 2'd0, 0, 32'h10, 32'h0000_0080, rd, f);
    xact(0, 0, 2'd0, 1, 32'h10, 32'h0, rd, f);
    chk("byte load signed", rd, 32'hFFFF_FF80);
    xact(0, 0, 2'd0, 0, 32'h10, 32'h0, rd, f);
    chk("byte load unsigned", rd, 32'h0000_0080);
    xact(0, 1, 2'd2, 0, 32'h20, 32'hCAFE_0000, rd, f);
    xact(0, 1, 2'd1, 0, 32'h20, 32'h0000_8001, rd, f);
    xact(0, 0, 2'd1, 1, 32'h20, 32'h0, rd, f);
    chk("half load signed", rd, 32'hFFFF_8001);
    xact(0, 0, 2'd1, 0, 32'h20, 32'h0, rd, f);
    chk("half load unsigned", rd, 32'h0000_8001);
    xact(0, 0, 2'd2, 0, 32'h102, 32'h0, rd, f);
    chk("misaligned word fault", 32'(f), 32'h1);
    chk("misaligned word rdata", rd, 32'h0);
    xact(0, 1, 2'd1, 0, 32'h21, 32'h0000_FFFF, rd, f);
    chk("misaligned half store fault", 32'(f), 32'h1);
    xact(0, 0, 2'd2, 0, 32'h20, 32'h0, rd, f);
    chk("faulted store wrote nothing", rd, 32'hCAFE_8001);
    xact(0, 0, 2'd3, 0, 32'h0, 32'h0, rd, f);
    chk("reserved size fault", 32'(f), 32'h1);
    xact(0, 0, 2'd2, 0, SIZE - 2, 32'h0, rd, f);
    chk("word @SIZE-2 fault", 32'(f), 32'h1);
    xact(0, 0, 2'd0, 0, SIZE, 32'h0, rd, f);
    chk("byte @SIZE fault", 32'(f), 32'h1);
    xact(0, 0, 2'd2, 0, 32'hFFFF_FFFC, 32'h0, rd, f);
    chk("word @top no-wrap fault", 32'(f), 32'h1);
    xact(0, 1, 2'd2, 0, SIZE - 4, 32'h0102_0304, rd, f);
    chk("word store @SIZE-4 fault", 32'(f), 32'h0);
    xact(0, 0, 2'd2, 0, SIZE - 4, 32'h0, rd, f);
    chk("word load @SIZE-4", rd, 32'h0102_0304);
    chk("word load @SIZE-4 fault", 32'(f), 32'h0);
    xact(0, 0, 2'd0, 0, SIZE - 1, 32'h0, rd, f);
    chk("byte load @SIZE-1", rd, 32'h0000_0001);

    // Latency 4: timing and backpressure.
    xact(1, 1, 2'd2, 0, 32'h200, 32'h55AA_7711, rd, f);
    resp_ready[1] = 1'b0;
    drive(1, 0, 2'd2, 0, 32'h200, 32'h0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    n = 0;
    while (!resp_valid[1] && n < 20) begin
      chk("L4 ready low in wait", 32'(req_ready[1]), 32'h0);
      @(posedge clk); #1;
      n++;
    end
    chk("L4 edges to resp_valid", n, 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("L4 held valid", 32'(resp_valid[1]), 32'h1);
      chk("L4 held rdata", resp_rdata[1], 32'h55AA_7711);
      chk("L4 held ready", 32'(req_ready[1]), 32'h0);
      @(posedge clk); #1;
    end
    // Handshake with a new request already waiting: it must not be taken on this edge.
    resp_ready[1] = 1'b1;
    drive(1, 0, 2'd1, 0, 32'h202, 32'h0);
    @(posedge clk); #1;
    chk("L4 idle after handshake", 32'(req_ready[1]), 32'h1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_resp(1, rd, f);
    chk("L4 follow-on half load", rd, 32'h0000_55AA);
    @(posedge clk); #1;

    // Reset during WAIT: response dropped, store kept.
    drive(1, 1, 2'd2, 0, 32'h40, 32'h1234_5678);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("L4 ready after reset", 32'(req_ready[1]), 32'h1);
    chk("L4 no valid after reset", 32'(resp_valid[1]), 32'h0);
    repeat (6) @(posedge clk);
    #1;
    xact(1, 0, 2'd2, 0, 32'h40, 32'h0, rd, f);
    chk("L4 store survives reset", rd, 32'h1234_5678);

    // Requests driven while busy are ignored.
    xact(1, 1, 2'd2, 0, 32'h50, 32'hA5A5_A5A5, rd, f);
    drive(1, 0, 2'd2, 0, 32'h200, 32'h0);
    @(posedge clk); #1;
    drive(1, 1, 2'd2, 0, 32'h50, 32'h1111_1111);
    repeat (2) @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_resp(1, rd, f);
    chk("L4 load during ignored store", rd, 32'h55AA_7711);
    @(posedge clk); #1;
    xact(1, 0, 2'd2, 0, 32'h50, 32'h0, rd, f);
    chk("L4 ignored store wrote nothing", rd, 32'hA5A5_A5A5);
    xact(1, 0, 2'd1, 0, 32'h51, 32'h0, rd, f);
    chk("L4 misaligned half fault", 32'(f), 32'h1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
